// File: rtl/cart_mmc1.sv
// cart_mmc1: MMC1-style cartridge responder.
// Serially loaded register file (shift/count), PRG and CHR bank expansion to
// external asynchronous ROMs, and CIRAM nametable mirroring control.
module cart_mmc1 #(
    parameter int unsigned PRG_ADDR_W = 18,
    parameter int unsigned CHR_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU side of the cartridge edge
    input  logic                  m2,
    input  logic                  rw,
    input  logic                  n_rom_sel,
    input  logic [14:0]           cpu_addr,
    input  logic [7:0]            cpu_data_in,
    output logic [7:0]            cpu_data_out,
    output logic                  cpu_data_oe,
    output logic                  n_irq,
    // PPU side of the cartridge edge
    input  logic                  n_rd,
    input  logic                  n_we,
    input  logic [13:0]           ppu_addr,
    output logic [7:0]            ppu_data_out,
    output logic                  ppu_data_oe,
    output logic                  n_vram_cs,
    output logic                  n_vram_a10,
    // External ROMs
    output logic [PRG_ADDR_W-1:0] prg_rom_addr,
    input  logic [7:0]            prg_rom_data,
    output logic [CHR_ADDR_W-1:0] chr_rom_addr,
    input  logic [7:0]            chr_rom_data
);

    localparam int unsigned SHIFT_W    = 5;
    localparam int unsigned COUNT_W    = 3;
    localparam int unsigned PRG_BANK_W = 4;
    localparam int unsigned CHR_BANK_W = 5;
    localparam int unsigned PRG_FULL_W = PRG_BANK_W + 14;
    localparam int unsigned CHR_FULL_W = CHR_BANK_W + 12;

    localparam logic [SHIFT_W-1:0] CONTROL_RST = 5'b01100;
    localparam logic [COUNT_W-1:0] LAST_BIT    = 3'd4;

    localparam logic [1:0] SEL_CONTROL = 2'd0;
    localparam logic [1:0] SEL_CHR0    = 2'd1;
    localparam logic [1:0] SEL_CHR1    = 2'd2;
    localparam logic [1:0] SEL_PRG     = 2'd3;

    // Bus sampling flops
    logic                  m2_q, m2_d;
    logic                  n_rom_sel_q, n_rom_sel_d;
    logic                  d0_q, d0_d;
    logic                  d7_q, d7_d;
    logic [1:0]            reg_sel_q, reg_sel_d;
    logic                  seen_low_q, seen_low_d;
    logic                  wr_last_q, wr_last_d;

    // Serial loader and register file
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [SHIFT_W-1:0]    control_q, control_d;
    logic [CHR_BANK_W-1:0] chr0_q, chr0_d;
    logic [CHR_BANK_W-1:0] chr1_q, chr1_d;
    logic [PRG_BANK_W-1:0] prg_q, prg_d;

    // Event decode
    logic                  m2_fall;
    logic                  wr_evt;
    logic [SHIFT_W-1:0]    shift_in;

    // Address expansion
    logic [PRG_BANK_W-1:0] prg_bank;
    logic [CHR_BANK_W-1:0] chr_bank;
    logic [PRG_FULL_W-1:0] prg_full;
    logic [CHR_FULL_W-1:0] chr_full;

    // Inputs that carry no information for this mapper
    logic                  unused_inputs;
    assign unused_inputs = ^{n_we, cpu_data_in[6:1]};

    // State register: all mapper state, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m2_q        <= 1'b0;
            n_rom_sel_q <= 1'b1;
            d0_q        <= 1'b0;
            d7_q        <= 1'b0;
            reg_sel_q   <= 2'd0;
            seen_low_q  <= 1'b0;
            wr_last_q   <= 1'b0;
            shift_q     <= '0;
            count_q     <= '0;
            control_q   <= CONTROL_RST;
            chr0_q      <= '0;
            chr1_q      <= '0;
            prg_q       <= '0;
        end else begin
            m2_q        <= m2_d;
            n_rom_sel_q <= n_rom_sel_d;
            d0_q        <= d0_d;
            d7_q        <= d7_d;
            reg_sel_q   <= reg_sel_d;
            seen_low_q  <= seen_low_d;
            wr_last_q   <= wr_last_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            control_q   <= control_d;
            chr0_q      <= chr0_d;
            chr1_q      <= chr1_d;
            prg_q       <= prg_d;
        end
    end

    // Write-event detection and serial register loading
    always_comb begin
        m2_d        = m2;
        n_rom_sel_d = n_rom_sel;
        d0_d        = cpu_data_in[0];
        d7_d        = cpu_data_in[7];
        reg_sel_d   = cpu_addr[14:13];
        // An m2 fall only counts once m2 has been seen low after reset, so a
        // cycle already in flight when reset releases cannot produce an event.
        seen_low_d  = seen_low_q | ~m2;
        wr_last_d   = wr_last_q;
        shift_d     = shift_q;
        count_d     = count_q;
        control_d   = control_q;
        chr0_d      = chr0_q;
        chr1_d      = chr1_q;
        prg_d       = prg_q;

        m2_fall  = m2_q & ~m2;
        wr_evt   = m2_fall & ~rw & ~n_rom_sel_q & seen_low_q;
        shift_in = {d0_q, shift_q[SHIFT_W-1:1]};

        if (wr_evt) begin
            wr_last_d = 1'b1;
            if (d7_q) begin
                shift_d         = '0;
                count_d         = '0;
                control_d[3:2]  = 2'b11;
            end else if (!wr_last_q) begin
                if (count_q == LAST_BIT) begin
                    shift_d = '0;
                    count_d = '0;
                    unique case (reg_sel_q)
                        SEL_CONTROL: control_d = shift_in;
                        SEL_CHR0:    chr0_d    = shift_in;
                        SEL_CHR1:    chr1_d    = shift_in;
                        SEL_PRG:     prg_d     = shift_in[PRG_BANK_W-1:0];
                        default:     prg_d     = prg_q;
                    endcase
                end else begin
                    shift_d = shift_in;
                    count_d = count_q + 3'd1;
                end
            end
        end else if (m2_fall) begin
            // A bus cycle that ended without a ROM write separates RMW writes
            wr_last_d = 1'b0;
        end
    end

    // PRG bank selection from control[3:2] and CPU A14
    always_comb begin
        prg_bank = '0;
        unique case (control_q[3:2])
            2'b00, 2'b01: prg_bank = {prg_q[3:1], cpu_addr[14]};
            2'b10:        prg_bank = cpu_addr[14] ? prg_q : 4'h0;
            2'b11:        prg_bank = cpu_addr[14] ? 4'hF : prg_q;
            default:      prg_bank = '0;
        endcase
        prg_full = {prg_bank, cpu_addr[13:0]};
    end

    // CHR bank selection from control[4] and PPU A12
    always_comb begin
        chr_bank = '0;
        if (control_q[4]) begin
            chr_bank = ppu_addr[12] ? chr1_q : chr0_q;
        end else begin
            chr_bank = {chr0_q[4:1], ppu_addr[12]};
        end
        chr_full = {chr_bank, ppu_addr[11:0]};
    end

    // Nametable mirroring: CIRAM A10 source from control[1:0]
    always_comb begin
        n_vram_a10 = 1'b0;
        unique case (control_q[1:0])
            2'b00:   n_vram_a10 = 1'b0;
            2'b01:   n_vram_a10 = 1'b1;
            2'b10:   n_vram_a10 = ppu_addr[10];
            2'b11:   n_vram_a10 = ppu_addr[11];
            default: n_vram_a10 = 1'b0;
        endcase
    end

    assign prg_rom_addr = PRG_ADDR_W'(prg_full);
    assign chr_rom_addr = CHR_ADDR_W'(chr_full);

    assign cpu_data_oe  = m2 & rw & ~n_rom_sel;
    assign cpu_data_out = prg_rom_data;
    assign n_irq        = 1'b1;

    assign ppu_data_oe  = ~n_rd & ~ppu_addr[13];
    assign ppu_data_out = chr_rom_data;
    assign n_vram_cs    = ~ppu_addr[13];

endmodule

// File: doc/cart_mmc1.md
Name: cart_mmc1

Overview:
- Cartridge-side responder for the console's cartridge edge. It is the other end of the CPU bus (m2, rw, n_rom_sel, cpu_addr, cpu_data) and the PPU bus (n_rd, n_we, ppu_addr, ppu_data).
- Implements an MMC1-style mapper: a serial-loaded register file, PRG and CHR bank address expansion to external ROMs, and nametable mirroring via n_vram_cs / n_vram_a10.
- Lets the console top be exercised against a realistic cartridge in simulation and on the FPGA.

Parameters:
- PRG_ADDR_W, 18, PRG-ROM byte address width (256 KB; 16 x 16 KB banks).
- CHR_ADDR_W, 17, CHR-ROM byte address width (128 KB; 32 x 4 KB banks).

Ports:
- clk  in  1  system clock; m2 is synchronous to it.
- reset  in  1  asynchronous, active-high.
- m2  in  1  CPU phase-2 clock from the console.
- rw  in  1  CPU read(1)/write(0).
- n_rom_sel  in  1  low when CPU A15=1 and m2=1.
- cpu_addr  in  15  CPU A14..A0.
- cpu_data_in  in  8  CPU data bus sampled.
- cpu_data_out  out  8  PRG read data.
- cpu_data_oe  out  1  drive enable for cpu_data.
- n_irq  out  1  constant 1 (no IRQ source).
- n_rd, n_we  in  1 each  PPU strobes.
- ppu_addr  in  14  PPU A13..A0.
- ppu_data_out  out  8  CHR read data.
- ppu_data_oe  out  1  drive enable for ppu_data.
- n_vram_cs  out  1  CIRAM chip select, active-low.
- n_vram_a10  out  1  CIRAM A10 level. The name is kept for port compatibility; the value is not inverted.
- prg_rom_addr  out  PRG_ADDR_W  external PRG-ROM address.
- prg_rom_data  in  8  external PRG-ROM data (asynchronous read).
- chr_rom_addr  out  CHR_ADDR_W  external CHR-ROM address.
- chr_rom_data  in  8  external CHR-ROM data (asynchronous read).

Behaviour:

Registers and reset:
- shift[4:0]=0, count[2:0]=0, control[4:0]=5'b01100, chr0[4:0]=0, chr1[4:0]=0, prg[3:0]=0, m2_q=0, wr_last=0.

Write event:
- Occurs on the clk where m2_q=1, m2=0, rw=0 and n_rom_sel_q=0, with n_rom_sel registered alongside m2.
- Data is taken from cpu_data_in as registered on the same edge as m2_q.

Event handling, one per event:
- Data bit7=1: shift=0, count=0, control[3:2]=2'b11. Always honoured.
- Otherwise, if wr_last=1, the event is ignored. This models the RMW double-write quirk.
- Otherwise: shift={d[0],shift[4:1]}, count+1.
- On the 5th accepted bit, the value {d[0],shift[4:1]} goes to the register chosen by cpu_addr[14:13]: 0 control, 1 chr0, 2 chr1, 3 prg (low 4 bits). Then shift=0, count=0.
- Register update is visible on the clk following the event (1-clk latency).

wr_last:
- Set to 1 on any write event, including ignored and reset ones.
- Cleared on an m2 falling edge with no ROM write.

PRG mapping (combinational; A14=cpu_addr[14]):
- control[3:2]=0 or 1: bank = {prg[3:1], A14}.
- control[3:2]=2: A14=0 gives bank 0; A14=1 gives prg.
- control[3:2]=3: A14=0 gives prg; A14=1 gives 4'hF.
- prg_rom_addr = {bank, cpu_addr[13:0]}, truncated or zero-extended to PRG_ADDR_W.
- cpu_data_oe = m2 & rw & ~n_rom_sel. cpu_data_out = prg_rom_data.
- Writes never drive the bus.

CHR mapping (combinational; A12=ppu_addr[12]):
- control[4]=0: bank = {chr0[4:1], A12}.
- control[4]=1: A12=0 gives chr0; A12=1 gives chr1.
- chr_rom_addr = {bank, ppu_addr[11:0]}.
- ppu_data_oe = ~n_rd & ~ppu_addr[13]. ppu_data_out = chr_rom_data.
- CHR writes (n_we=0) are ignored.

Nametables:
- n_vram_cs = ~ppu_addr[13].
- n_vram_a10 by control[1:0]: 0 gives 0; 1 gives 1; 2 gives ppu_addr[10] (vertical); 3 gives ppu_addr[11] (horizontal).

Boundary conditions:
- Reset asserted mid-sequence discards the partial shift immediately; the next load needs 5 fresh writes.
- A write with n_rom_sel high (address below $8000) is not an event.
- A bit7 reset on the 5th write commits nothing.
- A write whose m2 is still high when reset deasserts produces no event.

Test Plan:
- Apply reset, read $C000 (n_rom_sel=0, cpu_addr=0x4000, m2=1, rw=1) -> prg_rom_addr=0x3C000, cpu_data_oe=1; n_vram_a10=0 for ppu_addr=0x2C00.
- Write bits 0,1,0,0,0 (LSB first) to $E000, i.e. prg=2, in separate non-adjacent M2 cycles -> read $8000 gives prg_rom_addr=0x08000; $C000 stays 0x3C000.
- Load control=5'b10010 via $8000, chr0=3 via $A000, chr1=7 via $C000 -> ppu_addr=0x0123 gives chr_rom_addr=0x03123; ppu_addr=0x1123 gives 0x07123; ppu_addr=0x2400 gives n_vram_a10=1, n_vram_cs=0.
- After 3 serial writes, write 0x80 -> count=0. Then load 5'b00011 to $8000 -> mirroring horizontal (ppu_addr=0x2800 gives n_vram_a10=1); PRG mode = 0 (32 KB).
- Two writes on back-to-back M2 cycles -> only the first shifts (count +1). Assert reset mid-sequence -> registers return to reset values asynchronously.
